// File: rtl/modport_ahb_slave.sv
// AHB-Lite zero-wait-state memory slave: byte/halfword/word lanes, selectable
// endianness, and a two-cycle ERROR response for flagged or illegal transfers.
module modport_ahb_slave #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned DE = 0,
  parameter int unsigned RW = 2,
  parameter int unsigned MW = 10
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [DW-1:0] hwdata,
  input  logic          error,
  output logic [DW-1:0] hrdata,
  output logic          hready,
  output logic [RW-1:0] hresp
);
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned LNB   = $clog2(NB);
  localparam int unsigned DEPTH = 1 << MW;
  localparam logic [RW-1:0] RESP_OKAY  = RW'(0);
  localparam logic [RW-1:0] RESP_ERROR = RW'(1);

  typedef enum logic [1:0] {S_OKAY, S_ERR1, S_ERR2} state_e;

  state_e          state_q, state_d;
  logic            hready_q, hready_d;
  logic [RW-1:0]   hresp_q, hresp_d;
  logic            dp_valid_q, dp_valid_d;
  logic            dp_write_q, dp_write_d;
  logic [MW-1:0]   dp_addr_q, dp_addr_d;
  logic [2:0]      dp_size_q, dp_size_d;

  logic [7:0]      mem [DEPTH];

  logic            accept;
  logic            addr_err;
  logic [MW-1:0]   align_mask;
  logic [NB-1:0]   byte_en;
  logic            unused_inputs;

  // Upper address bits alias; burst/protection are informational only.
  assign unused_inputs = ^{hburst, hprot, htrans[0], haddr[AW-1:MW]};

  assign accept     = hready_q && htrans[1];
  assign align_mask = (MW'(1) << hsize) - MW'(1);
  assign addr_err   = error || (hsize > 3'(LNB)) || (|(haddr[MW-1:0] & align_mask));

  // Next-state: error transfers take ERR1 then ERR2; good ones open a data phase.
  always_comb begin
    state_d    = state_q;
    hready_d   = 1'b1;
    hresp_d    = RESP_OKAY;
    dp_valid_d = 1'b0;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    dp_size_d  = dp_size_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (accept) begin
      if (addr_err) begin
        state_d = S_ERR1;
      end else begin
        state_d    = S_OKAY;
        dp_valid_d = 1'b1;
        dp_write_d = hwrite;
        dp_addr_d  = haddr[MW-1:0];
        dp_size_d  = hsize;
      end
    end else begin
      state_d = S_OKAY;
    end
    hready_d = (state_d != S_ERR1);
    hresp_d  = (state_d == S_OKAY) ? RESP_OKAY : RESP_ERROR;
  end

  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state_q    <= S_OKAY;
      hready_q   <= 1'b1;
      hresp_q    <= RESP_OKAY;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_size_q  <= '0;
    end else begin
      state_q    <= state_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      dp_size_q  <= dp_size_d;
    end
  end

  assign hready = hready_q;
  assign hresp  = hresp_q;

  // Byte k of the word is active when it falls in the same size-aligned chunk.
  always_comb begin
    byte_en = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      byte_en[k] = ((k >> dp_size_q) == (32'(dp_addr_q[LNB-1:0]) >> dp_size_q));
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn && dp_valid_q && dp_write_q) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (byte_en[k]) begin
          mem[{dp_addr_q[MW-1:LNB], LNB'(k)}] <= hwdata[8*((DE != 0) ? (NB-1-k) : k) +: 8];
        end
      end
    end
  end

  // Read data is the whole word at the registered address, all lanes valid.
  always_comb begin
    hrdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      for (int unsigned k = 0; k < NB; k++) begin
        hrdata[8*((DE != 0) ? (NB-1-k) : k) +: 8] = mem[{dp_addr_q[MW-1:LNB], LNB'(k)}];
      end
    end
  end
endmodule

// File: tb/tb_modport_ahb_slave.sv
// Directed bench for modport_ahb_slave: little- and big-endian instances share
// stimulus and are checked every cycle against a byte-memory transfer model.
module tb_modport_ahb_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        err;
  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1;
  logic [1:0]  rsp0, rsp1;

  always #5 clk = ~clk;

  modport_ahb_slave #(.AW(32), .DW(32), .DE(0), .RW(2), .MW(10)) u_le (
    .hclk(clk), .hresetn(rst), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .error(err),
    .hrdata(rd0), .hready(rdy0), .hresp(rsp0));

  modport_ahb_slave #(.AW(32), .DW(32), .DE(1), .RW(2), .MW(10)) u_be (
    .hclk(clk), .hresetn(rst), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .error(err),
    .hrdata(rd1), .hready(rdy1), .hresp(rsp1));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: byte memories per endianness, one pending data phase, error cycle count.
  logic [7:0]  m0 [1024];
  logic [7:0]  m1 [1024];
  bit          m_rdy = 1'b1;
  logic [1:0]  m_rsp = 2'd0;
  bit          pv = 1'b0;
  bit          pw = 1'b0;
  int unsigned pa = 0;
  int unsigned psz = 0;
  int          errph = 0;
  int unsigned ma;

  always @(posedge clk) begin
    if (rst) begin
      pv = 1'b0;
      errph = 0;
    end else begin
      if (pv && pw) begin
        for (int i = 0; i < (1 << psz); i++) begin
          ma = pa + i;
          m0[ma] = hwdata[8*(ma%4) +: 8];
          m1[ma] = hwdata[8*(3-(ma%4)) +: 8];
        end
      end
      if (errph == 1) begin
        errph = 2;
        pv = 1'b0;
      end else if (m_rdy && htrans[1]) begin
        ma = haddr % 1024;
        if (err || hsize > 3'd2 || (ma % (1 << hsize)) != 0) begin
          errph = 1;
          pv = 1'b0;
        end else begin
          errph = 0;
          pv = 1'b1;
          pw = hwrite;
          pa = ma;
          psz = hsize;
        end
      end else begin
        errph = 0;
        pv = 1'b0;
      end
    end
    m_rdy = (errph != 1);
    m_rsp = (errph != 0) ? 2'd1 : 2'd0;
  end

  function automatic logic [31:0] exp_rd(input bit be);
    logic [31:0] w;
    w = '0;
    if (pv && !pw) begin
      for (int o = 0; o < 4; o++) begin
        int unsigned b;
        b = (pa & ~32'd3) + o;
        if (be) w[8*(3-o) +: 8] = m1[b];
        else    w[8*o +: 8] = m0[b];
      end
    end
    return w;
  endfunction

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("le_hready", 32'(rdy0), 32'(m_rdy));
      chk("le_hresp",  32'(rsp0), 32'(m_rsp));
      chk("le_hrdata", rd0, exp_rd(1'b0));
      chk("be_hready", 32'(rdy1), 32'(m_rdy));
      chk("be_hresp",  32'(rsp1), 32'(m_rsp));
      chk("be_hrdata", rd1, exp_rd(1'b1));
    end
  end

  logic [31:0] next_wd;

  // Presents one address phase; hwdata carries the previous beat's write data.
  task automatic beat(input logic [1:0] tr, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic e, input logic [31:0] wd);
    htrans  = tr;
    hwrite  = w;
    hsize   = sz;
    haddr   = a;
    err     = e;
    hwdata  = next_wd;
    next_wd = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    beat(2'b00, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0);
  endtask

  localparam logic [1:0] NS = 2'b10, SQ = 2'b11, BZ = 2'b01;

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 1024; i++) begin
      m0[i] = 8'h00;
      m1[i] = 8'h00;
    end
    rst = 1'b1; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0;
    hprot = 4'd0; haddr = 32'h0; hwdata = 32'h0; err = 1'b0; next_wd = 32'h0;

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hready", 32'(rdy0), 32'd1);
    chk("rst_hresp",  32'(rsp0), 32'd0);
    chk("rst_hrdata", rd0, 32'h0);

    beat(NS, 1'b1, 3'd2, 32'h10, 1'b0, 32'hDEADBEEF);
    beat(NS, 1'b0, 3'd2, 32'h10, 1'b0, 32'h0);
    @(negedge clk);
    chk("word_rd_le", rd0, 32'hDEADBEEF);
    chk("word_rd_be", rd1, 32'hDEADBEEF);

    for (int i = 0; i < 4; i++) begin
      b = 8'((i + 1) * 17);
      beat((i == 0) ? NS : SQ, 1'b1, 3'd0, 32'h20 + 32'(i), 1'b0, {4{b}});
    end
    beat(NS, 1'b0, 3'd2, 32'h20, 1'b0, 32'h0);
    @(negedge clk);
    chk("bytes_le", rd0, 32'h44332211);
    chk("bytes_be", rd1, 32'h11223344);

    beat(NS, 1'b1, 3'd2, 32'h30, 1'b0, 32'h0);
    beat(NS, 1'b1, 3'd1, 32'h32, 1'b0, 32'hABCDABCD);
    beat(NS, 1'b0, 3'd2, 32'h30, 1'b0, 32'h0);
    @(negedge clk);
    chk("half_le", rd0, 32'hABCD0000);
    chk("half_be", rd1, 32'h0000ABCD);

    beat(NS, 1'b1, 3'd2, 32'h40, 1'b0, 32'h12345678);
    beat(NS, 1'b1, 3'd2, 32'h40, 1'b1, 32'hFFFFFFFF);
    @(negedge clk);
    chk("err1_hready", 32'(rdy0), 32'd0);
    chk("err1_hresp",  32'(rsp0), 32'd1);
    chk("err1_hrdata", rd0, 32'h0);
    idle();
    @(negedge clk);
    chk("err2_hready", 32'(rdy0), 32'd1);
    chk("err2_hresp",  32'(rsp0), 32'd1);
    beat(NS, 1'b0, 3'd2, 32'h40, 1'b0, 32'h0);
    @(negedge clk);
    chk("err_old_data", rd0, 32'h12345678);
    chk("err_after_resp", 32'(rsp0), 32'd0);

    beat(NS, 1'b0, 3'd2, 32'h41, 1'b0, 32'h0);
    @(negedge clk);
    chk("mis_err1_hready", 32'(rdy0), 32'd0);
    chk("mis_err1_hresp",  32'(rsp0), 32'd1);
    idle();
    @(negedge clk);
    chk("mis_err2_hresp", 32'(rsp0), 32'd1);
    idle();
    @(negedge clk);
    chk("mis_cancel_hresp", 32'(rsp0), 32'd0);

    beat(NS, 1'b0, 3'd3, 32'h40, 1'b0, 32'h0);
    idle();
    idle();
    beat(NS, 1'b1, 3'd1, 32'h31, 1'b0, 32'hFFFFFFFF);
    idle();
    idle();
    beat(NS, 1'b0, 3'd2, 32'h30, 1'b0, 32'h0);
    @(negedge clk);
    chk("mis_half_nochg", rd0, 32'hABCD0000);

    beat(NS, 1'b1, 3'd2, 32'h54, 1'b0, 32'h01010101);
    beat(NS, 1'b1, 3'd2, 32'h50, 1'b0, 32'hCAFEF00D);
    beat(BZ, 1'b1, 3'd2, 32'h54, 1'b0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("busy_hready", 32'(rdy0), 32'd1);
    chk("busy_hresp",  32'(rsp0), 32'd0);
    beat(SQ, 1'b0, 3'd2, 32'h54, 1'b0, 32'h0);
    @(negedge clk);
    chk("busy_nochg", rd0, 32'h01010101);
    beat(NS, 1'b0, 3'd2, 32'h50, 1'b0, 32'h0);
    @(negedge clk);
    chk("burst_word", rd0, 32'hCAFEF00D);

    beat(NS, 1'b1, 3'd2, 32'h0000_0410, 1'b0, 32'h5A5AA5A5);
    beat(NS, 1'b0, 3'd2, 32'h10, 1'b0, 32'h0);
    @(negedge clk);
    chk("alias_rd", rd0, 32'h5A5AA5A5);

    beat(NS, 1'b0, 3'd2, 32'h43, 1'b0, 32'h0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_err_hready", 32'(rdy0), 32'd1);
    chk("rst_in_err_hresp",  32'(rsp0), 32'd0);

    idle();
    idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/modport_ahb_slave.md
Name: modport_ahb_slave

Overview:
AHB-Lite memory slave: pipelined address/data phases, byte/halfword/word accesses, configurable endianness, zero-wait-state OKAY transfers. Sits behind the AHB master interface, which drives address/control/write data and a wired-OR `error` request line. The slave returns `hrdata`, `hready` and `hresp`. The master can force an ERROR response on a transfer.

Parameters:
AW, 32, address bus width
DW, 32, data bus width (32 or 64)
DE, 0, endianness: 0 = little, 1 = big
RW, 2, hresp width; OKAY = 0, ERROR = 1
MW, 10, implemented memory address bits (2^MW bytes); haddr[MW-1:0] used, upper bits ignored

Ports:
hclk  input  1  bus clock; all logic on rising edge
hresetn  input  1  synchronous active-high reset (1 = reset); bus-standard name kept
haddr  input  AW  byte address (address phase)
htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  input  1  1 = write, 0 = read
hsize  input  3  0 byte, 1 halfword, 2 word, 3 dword (DW=64 only)
hburst  input  3  burst type; informational only
hprot  input  4  protection; informational only
hwdata  input  DW  write data (data phase)
error  input  1  master request: respond ERROR to the transfer in its address phase
hrdata  output  DW  read data (data phase)
hready  output  1  1 = transfer done / bus may advance
hresp  output  RW  transfer response

Behaviour:
- Interface: one clock `hclk`; `hresetn` is synchronous and active-high.
- Reset (hresetn=1 at posedge):
  - hready=1, hresp=OKAY, hrdata=0.
  - Pending data phase and error state are cleared; in-flight writes are dropped.
  - Memory contents are not cleared.
- Address phase is accepted at a posedge with hready=1 and htrans NONSEQ or SEQ.
  - Registered: haddr[MW-1:0], hwrite, hsize, and an error flag.
  - Error flag = error OR hsize > log2(DW/8) OR address misaligned for hsize.
- IDLE/BUSY with hready=1: no data phase; next cycle hready=1, hresp=OKAY, no memory access.
- Data phase, OKAY case (zero wait): hready=1, hresp=OKAY.
  - Read: hrdata driven combinationally from memory at the registered address. Full DW word containing the address is returned; all lanes valid.
  - Write: byte lanes selected by registered hsize and address low bits are written from hwdata at the posedge ending the data phase. Other bytes are unchanged.
- Lane mapping for byte offset k within the DW word (NB = DW/8):
  - DE=0: lane k = hwdata/hrdata bits [8k+7:8k].
  - DE=1: lane NB-1-k.
- Read immediately after write to the same address: the write commits at the end of its data phase, before the read's data phase, so new data is returned. No forwarding is needed.
- ERROR response (two-cycle, per AHB):
  - Cycle 1: hready=0, hresp=ERROR. Write suppressed; hrdata=0.
  - Cycle 2: hready=1, hresp=ERROR.
  - The next address is accepted only at the end of cycle 2.
  - If the master presents IDLE in cycle 2 (burst cancel), no further transfer occurs.
- No new address is accepted while hready=0; address inputs are ignored in ERROR cycle 1.
- hburst and hprot do not affect behaviour. Every beat uses the master-supplied haddr; no internal address increment.
- Address wrap: haddr bits above MW are ignored, so accesses alias modulo 2^MW.
- Back-to-back transfers (NONSEQ/SEQ every cycle) sustain one transfer per clock.

Test Plan:
1. Reset held 2 cycles, then released -> hready=1, hresp=0, hrdata=0.
2. Word write 0xDEADBEEF @0x10, then word read @0x10 back-to-back -> hrdata=0xDEADBEEF; hready=1 and hresp=OKAY throughout.
3. DE=0: byte writes 0x11,0x22,0x33,0x44 to 0x20..0x23, word read @0x20 -> 0x44332211. DE=1: same sequence -> 0x11223344.
4. Halfword write 0xABCD @0x32 over prior word 0 @0x30, read @0x30 -> 0xABCD0000 (DE=0).
5. Write @0x40 with error=1 in address phase -> data phase cycle 1: hready=0, hresp=1; cycle 2: hready=1, hresp=1. Subsequent read @0x40 returns the old value.
6. Word access @0x41 (misaligned) -> two-cycle ERROR. BUSY cycle mid-burst -> OKAY, no memory change. Reset asserted during an ERROR cycle 1 -> hready=1, hresp=0 on the next cycle.
